tmem_master: RTL and testbench
==============================

TMEM_MASTER -- requirements
Module: tmem_master

Interface
REQ-001 SHALL have parameter MAXLEN, default 16, meaning the maximum burst length in words; cmd_len width is clog2(MAXLEN).
REQ-002 SHALL have ports: clk in 1, clock; all logic on rising edge.
REQ-003 reset in 1, synchronous, active-high.
REQ-004 cmd_valid in 1, command request.
REQ-005 cmd_ready out 1, high only in IDLE.
REQ-006 cmd_op in 2, operation: 00 read burst, 01 write burst, 10 atomic swap, 11 reserved and treated as read.
REQ-007 cmd_addr in 20, start word address.
REQ-008 cmd_len in 4, burst length minus 1 (1..16 words); ignored for swap.
REQ-009 cmd_force in 1, override tag-bit-3 write protection.
REQ-010 wdata_valid in 1 / wdata_ready out 1, host write-data handshake.
REQ-011 wdata in 64, wtag in 8, write word and tag.
REQ-012 rdata_ready in 1, host can accept one read word.
REQ-013 rdata_valid out 1, rdata out 64, rtag out 8, read word and tag.
REQ-014 done out 1, one-cycle completion pulse; err out 1, write-protect abort flag, valid with done.
REQ-015 count out 5, words transferred in the current or last command.
REQ-016 m_ad out 64, m_tag out 8, m_astb out 1, m_atomic out 1, m_rd out 1, m_wr out 1, m_wforce out 1: memory bus outputs.
REQ-017 m_data in 64, m_tagin in 8: memory read data and tag, registered by the memory.

Function
REQ-018 States SHALL be IDLE, ADDR, READ, WRITE, SWR, DONE.
REQ-019 IDLE: on cmd_valid, latch op, addr, len, and force; clear count and err; go to ADDR.
REQ-020 ADDR: drive m_astb=1 and m_ad={44'b0,addr} for exactly one cycle.
REQ-021 ADDR next state: read or swap goes to READ; write goes to WRITE.
REQ-022 READ: assert m_rd in a cycle only if rdata_ready is high that cycle.
REQ-023 The memory result SHALL be presented the following cycle as rdata_valid=1, rdata=m_data, rtag=m_tagin, without re-checking rdata_ready.
REQ-024 Back-to-back m_rd cycles SHALL be allowed, with throughput of 1 word per cycle.
REQ-025 Read burst: after len+1 m_rd cycles, wait for the last rdata_valid, then go to DONE.
REQ-026 WRITE: the tag of the current address is m_tagin, valid from the cycle after ADDR or after the previous write.
REQ-027 WRITE: if m_tagin[3]=1 and force=0, SHALL NOT assert m_wr; set err=1 and go to DONE.
REQ-028 WRITE otherwise: when wdata_valid, assert m_wr=1 and wdata_ready=1, with m_ad=wdata, m_tag=wtag, m_wforce=force; increment count.
REQ-029 WRITE: the protection check SHALL repeat before every word, because the memory updates m_tagin on each non-atomic write edge.
REQ-030 Write burst: after len+1 writes, go to DONE.
REQ-031 Write handshake: no m_wr while wdata_valid=0; the state is held indefinitely.
REQ-032 Swap: the READ cycle SHALL use m_atomic=1 with one word, returning the old word on rdata; then go to SWR.
REQ-033 SWR: m_atomic=1; protection check as in WRITE, against m_tagin from the atomic read; on pass, write wdata to the same address.
REQ-034 m_atomic SHALL be 0 for all read and write bursts.
REQ-035 count SHALL increment per word read (on rdata_valid) and per word written.
REQ-036 Address SHALL wrap from 0xFFFFF to 0x00000, matching the memory's 20-bit auto-increment; bursts crossing the wrap SHALL be legal.
REQ-037 DONE: done=1 for one cycle, then IDLE; err SHALL hold until the next accepted command.
REQ-038 A new cmd_valid during DONE SHALL NOT be accepted until IDLE.
REQ-039 At most one of m_astb, m_rd, m_wr SHALL be high in any cycle.

Reset
REQ-040 reset SHALL force IDLE at the next clk edge, including mid-burst.
REQ-041 On reset, all m_* strobes, done, err, rdata_valid, wdata_ready = 0; count = 0; m_ad = 0; m_tag = 0; cmd_ready = 1 the cycle after reset deasserts.
REQ-042 A read word in flight at reset SHALL be discarded, with no rdata_valid.

Verification
REQ-043 Read burst: addr=0x00010, len=3, rdata_ready=1 -> 1 astb, 4 consecutive m_rd, rdata_valid for 4 cycles with mem[0x10..0x13], done, count=4, err=0.
REQ-044 Write, protected: addr=0x00020, len=1, tag[0x21][3]=1, force=0 -> word 0x20 written, no m_wr for 0x21, done with err=1, count=1, mem[0x21] unchanged.
REQ-045 Same protected write with force=1 -> both words written with m_wforce=1, err=0, count=2.
REQ-046 Swap: addr=0x00005, mem=0xAAAA, wdata=0x5555 -> m_atomic=1 on rd and wr, rdata=0xAAAA, mem[5]=0x5555, single astb.
REQ-047 Wrap: read addr=0xFFFFE, len=2 -> data from 0xFFFFE, 0xFFFFF, 0x00000 (0xFFFFE returns the latched-address register value).
REQ-048 Stall and reset: write len=3 with wdata_valid low for 5 cycles mid-burst -> no m_wr while low; reset asserted mid-burst -> all strobes low next cycle, state IDLE, count=0.

Source files
------------

// File: rtl/tmem_master.sv
// tmem_master: bus master for a tagged word memory. It runs read bursts,
// write bursts with per-word tag-bit-3 write protection, and atomic swaps.
//
// Handshakes: cmd_valid/cmd_ready is a valid/ready pair (cmd_ready only in IDLE),
// and a command is taken on a clk edge where both are high.
// wdata_valid/wdata_ready is a valid/ready pair, and a word moves on an edge where
// both are high. wdata_ready is never raised without wdata_valid.
// rdata_ready is a permission: a read is issued only in a cycle where it is high.
// The word then arrives as rdata_valid the next cycle without being stalled.
// The bus strobes are decoded from the registered state.
// Memory read data and tags are already registered by the memory, so they
// pass straight through to rdata/rtag.
module tmem_master #(
   parameter int MAXLEN = 16,
   localparam int LW = $clog2(MAXLEN),
   localparam int CW = LW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [19:0]   cmd_addr,
   input  logic [LW-1:0] cmd_len,
   input  logic          cmd_force,
   input  logic          wdata_valid,
   output logic          wdata_ready,
   input  logic [63:0]   wdata,
   input  logic [7:0]    wtag,
   input  logic          rdata_ready,
   output logic          rdata_valid,
   output logic [63:0]   rdata,
   output logic [7:0]    rtag,
   output logic          done,
   output logic          err,
   output logic [CW-1:0] count,
   output logic [63:0]   m_ad,
   output logic [7:0]    m_tag,
   output logic          m_astb,
   output logic          m_atomic,
   output logic          m_rd,
   output logic          m_wr,
   output logic          m_wforce,
   input  logic [63:0]   m_data,
   input  logic [7:0]    m_tagin,
   output logic [2:0]    dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_READ  = 3'd2,
      S_WRITE = 3'd3,
      S_SWR   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_SWAP  = 2'b10;

   state_t        state;
   logic [1:0]    op_q;
   logic [19:0]   addr_q;
   logic [LW-1:0] len_q;
   logic          force_q;
   logic [CW-1:0] rd_left;   // reads still to issue in this burst
   logic          rd_pend;   // a read was issued last cycle, its word is on m_data now
   logic          prot;
   logic          rd_fire;
   logic          wr_fire;
   logic          unused_tag;

   // Handshake decode: issue reads only with host permission, and write only when
   // the tag of the current word does not forbid it.
   always_comb begin
      prot    = m_tagin[3] & ~force_q;
      rd_fire = (state == S_READ) && (rd_left != '0) && rdata_ready;
      wr_fire = ((state == S_WRITE) || (state == S_SWR)) && !prot && wdata_valid;
   end

   // Bus and host outputs derived from the registered state.
   always_comb begin
      m_ad = '0;
      if (state == S_ADDR)
         m_ad = {44'b0, addr_q};
      else if (wr_fire)
         m_ad = wdata;
   end

   assign m_astb      = (state == S_ADDR);
   assign m_rd        = rd_fire;
   assign m_wr        = wr_fire;
   assign wdata_ready = wr_fire;
   assign m_tag       = wr_fire ? wtag : 8'h00;
   assign m_wforce    = wr_fire & force_q;
   assign m_atomic    = (op_q == OP_SWAP) && ((state == S_READ) || (state == S_SWR));
   assign cmd_ready   = (state == S_IDLE);
   assign rdata_valid = rd_pend;
   assign rdata       = m_data;
   assign rtag        = m_tagin;
   assign dbg_state   = state;
   assign unused_tag  = ^{m_tagin[7:4], m_tagin[2:0]};

   // Command sequencing, word counting and completion status.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         op_q    <= 2'b00;
         addr_q  <= '0;
         len_q   <= '0;
         force_q <= 1'b0;
         rd_left <= '0;
         rd_pend <= 1'b0;
         count   <= '0;
         err     <= 1'b0;
         done    <= 1'b0;
      end else begin
         rd_pend <= rd_fire;
         done    <= 1'b0;
         if (rd_pend || wr_fire)
            count <= count + CW'(1);
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_q    <= cmd_op;
                  addr_q  <= cmd_addr;
                  len_q   <= cmd_len;
                  force_q <= cmd_force;
                  count   <= '0;
                  err     <= 1'b0;
                  state   <= S_ADDR;
               end
            end
            S_ADDR: begin
               // A swap is always a single word, so its length field is ignored.
               rd_left <= (op_q == OP_SWAP) ? CW'(1) : CW'(len_q) + CW'(1);
               state   <= (op_q == OP_WRITE) ? S_WRITE : S_READ;
            end
            S_READ: begin
               if (rd_fire)
                  rd_left <= rd_left - CW'(1);
               // Leave once every read is issued and the final word is on rdata.
               if ((rd_left == '0) && rd_pend) begin
                  if (op_q == OP_SWAP) begin
                     state <= S_SWR;
                  end else begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end
               end
            end
            S_WRITE: begin
               if (prot) begin
                  err   <= 1'b1;
                  state <= S_DONE;
                  done  <= 1'b1;
               end else if (wdata_valid && (count == CW'(len_q))) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            S_SWR: begin
               if (prot) begin
                  err   <= 1'b1;
                  state <= S_DONE;
                  done  <= 1'b1;
               end else if (wdata_valid) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tmem_master.sv
// Bench for tmem_master: a tagged memory on the bus side and a random host
// on the command side. A transaction-level reference memory predicts each
// command's read words, final memory contents, count and err.
module tb_tmem_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_ready, cmd_force;
   logic [1:0]  cmd_op;
   logic [19:0] cmd_addr;
   logic [3:0]  cmd_len;
   logic        wdata_valid, wdata_ready;
   logic [63:0] wdata;
   logic [7:0]  wtag;
   logic        rdata_ready, rdata_valid;
   logic [63:0] rdata;
   logic [7:0]  rtag;
   logic        done, err;
   logic [4:0]  count;
   logic [63:0] m_ad;
   logic [7:0]  m_tag;
   logic        m_astb, m_atomic, m_rd, m_wr, m_wforce;
   logic [63:0] m_data = '0;
   logic [7:0]  m_tagin = '0;
   logic [2:0]  dbg_state;

   always #5 clk = ~clk;

   tmem_master #(.MAXLEN(16)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_force(cmd_force),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wtag(wtag),
      .rdata_ready(rdata_ready), .rdata_valid(rdata_valid), .rdata(rdata), .rtag(rtag),
      .done(done), .err(err), .count(count), .m_ad(m_ad), .m_tag(m_tag),
      .m_astb(m_astb), .m_atomic(m_atomic), .m_rd(m_rd), .m_wr(m_wr),
      .m_wforce(m_wforce), .m_data(m_data), .m_tagin(m_tagin), .dbg_state(dbg_state)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- memories: bus-side (driven by DUT) and reference ----------
   logic [63:0] bmem[int];
   logic [7:0]  btag[int];
   logic [63:0] rmem[int];
   logic [7:0]  rtg[int];
   logic [19:0] mar = '0;

   function automatic logic [63:0] dflt(input logic [19:0] a);
      return 64'hD000_0000_0000_0000 | {44'b0, a};
   endfunction
   function automatic logic [63:0] bus_rd(input logic [19:0] a);
      return bmem.exists(int'(a)) ? bmem[int'(a)] : dflt(a);
   endfunction
   function automatic logic [7:0] bus_tg(input logic [19:0] a);
      return btag.exists(int'(a)) ? btag[int'(a)] : 8'h00;
   endfunction
   function automatic logic [63:0] ref_rd(input logic [19:0] a);
      return rmem.exists(int'(a)) ? rmem[int'(a)] : dflt(a);
   endfunction
   function automatic logic [7:0] ref_tg(input logic [19:0] a);
      return rtg.exists(int'(a)) ? rtg[int'(a)] : 8'h00;
   endfunction

   task automatic poke(input logic [19:0] a, input logic [63:0] d, input logic [7:0] t);
      bmem[int'(a)] = d; btag[int'(a)] = t;
      rmem[int'(a)] = d; rtg[int'(a)]  = t;
   endtask

   // ---------------- host driver and scoreboard state ----------------
   logic [71:0] exp_q[$];
   logic [71:0] wq[$];
   logic host_auto = 1'b0;
   logic always_ready = 1'b0;
   int cyc = 0;
   int astb_cnt, rd_cnt, wr_cnt, wf_cnt, at_rd, at_wr;
   int strobe_viol, rd_viol, wr_viol, first_rd, last_rd;

   // Random host: read permission and write-data presentation change at negedge.
   always @(negedge clk) begin
      if (host_auto) begin
         rdata_ready = always_ready ? 1'b1 : ($urandom_range(0, 3) != 0);
         wdata_valid = (wq.size() != 0) && (always_ready || ($urandom_range(0, 3) != 0));
         wdata = (wq.size() != 0) ? wq[0][63:0] : 64'h0;
         wtag  = (wq.size() != 0) ? wq[0][71:64] : 8'h00;
      end
   end

   // Memory model plus bus/host monitor on the active edge.
   always @(posedge clk) begin
      cyc++;
      if (!reset) begin
         if ((int'(m_astb) + int'(m_rd) + int'(m_wr)) > 1) strobe_viol++;
         if (m_rd && !rdata_ready) rd_viol++;
         if (m_wr && !wdata_valid) wr_viol++;
         if (m_astb) astb_cnt++;
         if (m_rd) begin
            rd_cnt++;
            if (rd_cnt == 1) first_rd = cyc;
            last_rd = cyc;
         end
         if (m_wr) wr_cnt++;
         if (m_wr && m_wforce) wf_cnt++;
         if (m_atomic && m_rd) at_rd++;
         if (m_atomic && m_wr) at_wr++;
         if (rdata_valid) begin
            if (exp_q.size() == 0) check("rd_extra", 72'(1), 72'(0));
            else check("rdata", {rtag, rdata}, exp_q.pop_front());
         end
         if (wdata_valid && wdata_ready && (wq.size() != 0)) void'(wq.pop_front());
      end
      if (m_astb) begin
         mar = m_ad[19:0];
         m_tagin <= bus_tg(mar);
      end else if (m_rd) begin
         m_data  <= bus_rd(mar);
         m_tagin <= bus_tg(mar);
         if (!m_atomic) mar = mar + 20'd1;
      end else if (m_wr) begin
         bmem[int'(mar)] = m_ad;
         btag[int'(mar)] = m_tag;
         if (!m_atomic) mar = mar + 20'd1;
         m_tagin <= bus_tg(mar);
      end
   end

   // ---------------- one command: predict, drive, check ----------------
   task automatic run_cmd(input logic [1:0] op, input logic [19:0] addr, input logic [3:0] len,
                          input logic frc, input logic [63:0] w0);
      int exp_cnt, nw, t, exp_rd, exp_wr, span;
      logic exp_err;
      logic [19:0] a;
      logic [7:0] tg;
      logic [71:0] w;
      logic [71:0] wlist[$];
      exp_cnt = 0; exp_err = 1'b0;
      nw = (op == 2'b10) ? 1 : ((op == 2'b01) ? int'(len) + 1 : 0);
      for (int i = 0; i < nw; i++) begin
         w = {8'($urandom), $urandom, $urandom};
         if (i == 0) w[63:0] = w0;
         wlist.push_back(w);
      end
      span = (op == 2'b10) ? 1 : int'(len) + 1;
      case (op)
         2'b01: begin
            for (int i = 0; i <= int'(len); i++) begin
               a = addr + 20'(i);
               tg = ref_tg(a);
               if (tg[3] && !frc) begin
                  exp_err = 1'b1;
                  break;
               end
               rmem[int'(a)] = wlist[i][63:0];
               rtg[int'(a)]  = wlist[i][71:64];
               exp_cnt++;
            end
         end
         2'b10: begin
            tg = ref_tg(addr);
            exp_q.push_back({tg, ref_rd(addr)});
            exp_cnt = 1;
            if (tg[3] && !frc) exp_err = 1'b1;
            else begin
               rmem[int'(addr)] = wlist[0][63:0];
               rtg[int'(addr)]  = wlist[0][71:64];
               exp_cnt = 2;
            end
         end
         default: begin
            for (int i = 0; i <= int'(len); i++) begin
               a = addr + 20'(i);
               exp_q.push_back({ref_tg(a), ref_rd(a)});
            end
            exp_cnt = int'(len) + 1;
         end
      endcase
      exp_rd = (op == 2'b01) ? 0 : ((op == 2'b10) ? 1 : int'(len) + 1);
      exp_wr = (op == 2'b01) ? exp_cnt : ((op == 2'b10) ? exp_cnt - 1 : 0);

      astb_cnt = 0; rd_cnt = 0; wr_cnt = 0; wf_cnt = 0; at_rd = 0; at_wr = 0;
      strobe_viol = 0; rd_viol = 0; wr_viol = 0; first_rd = 0; last_rd = 0;
      wq = wlist;

      t = 0;
      while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
      check("cmd_ready", 72'(cmd_ready), 72'(1));
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_force = frc;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("accepted", 72'(cmd_ready), 72'(0));
      t = 0;
      while (!done && t < 3000) begin @(negedge clk); t++; end
      check("done_seen", 72'(done), 72'(1));
      check("err", 72'(err), 72'(exp_err));
      check("count", 72'(count), 72'(exp_cnt));
      check("ready_in_done", 72'(cmd_ready), 72'(0));
      @(negedge clk);
      check("done_pulse", 72'(done), 72'(0));
      check("idle_ready", 72'(cmd_ready), 72'(1));
      check("err_hold", 72'(err), 72'(exp_err));
      check("rd_left_over", 72'(exp_q.size()), 72'(0));
      check("astb_cnt", 72'(astb_cnt), 72'(1));
      check("rd_cnt", 72'(rd_cnt), 72'(exp_rd));
      check("wr_cnt", 72'(wr_cnt), 72'(exp_wr));
      check("wforce_cnt", 72'(wf_cnt), 72'(frc ? exp_wr : 0));
      check("atomic_rd", 72'(at_rd), 72'((op == 2'b10) ? 1 : 0));
      check("atomic_wr", 72'(at_wr), 72'((op == 2'b10) ? exp_wr : 0));
      check("strobe_onehot", 72'(strobe_viol), 72'(0));
      check("rd_no_perm", 72'(rd_viol), 72'(0));
      check("wr_no_valid", 72'(wr_viol), 72'(0));
      for (int i = 0; i < span; i++) begin
         a = addr + 20'(i);
         check("mem", {bus_tg(a), bus_rd(a)}, {ref_tg(a), ref_rd(a)});
      end
      exp_q.delete();
      wq.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog no_finish got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      logic [19:0] ra;
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_len = '0;
      cmd_force = 1'b0; wdata_valid = 1'b0; wdata = '0; wtag = '0; rdata_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_ready", 72'(cmd_ready), 72'(1));
      check("rst_state", 72'(dbg_state), 72'(0));
      check("rst_count", 72'(count), 72'(0));
      check("rst_flags", {done, err, rdata_valid, wdata_ready}, 72'(0));
      check("rst_strobes", {m_astb, m_rd, m_wr, m_atomic, m_wforce}, 72'(0));
      check("rst_bus", {m_tag, m_ad}, 72'(0));

      host_auto = 1'b1;
      // Read burst at 0x10, four words back to back.
      for (int i = 0; i < 4; i++) poke(20'h00010 + 20'(i), {$urandom, $urandom}, 8'($urandom));
      always_ready = 1'b1;
      run_cmd(2'b00, 20'h00010, 4'd3, 1'b0, 64'h0);
      check("rd_back_to_back", 72'(last_rd - first_rd), 72'(3));
      always_ready = 1'b0;

      // Protected second word, without and then with force.
      poke(20'h00021, 64'h1111_2222_3333_4444, 8'h08);
      run_cmd(2'b01, 20'h00020, 4'd1, 1'b0, {$urandom, $urandom});
      check("prot_word_kept", 72'(bus_rd(20'h00021)), 72'(64'h1111_2222_3333_4444));
      poke(20'h00020, 64'h0, 8'h00);
      poke(20'h00021, 64'h1111_2222_3333_4444, 8'h08);
      run_cmd(2'b01, 20'h00020, 4'd1, 1'b1, {$urandom, $urandom});

      // Swap.
      poke(20'h00005, 64'hAAAA, 8'h00);
      run_cmd(2'b10, 20'h00005, 4'd7, 1'b0, 64'h5555);
      check("swap_mem", 72'(bus_rd(20'h00005)), 72'(64'h5555));

      // Read across the 20-bit wrap.
      run_cmd(2'b00, 20'hFFFFE, 4'd2, 1'b0, 64'h0);

      // Random commands around a low window and around the wrap point.
      for (int i = 0; i < 8; i++) poke(20'($urandom_range(0, 63)), {$urandom, $urandom}, 8'h08);
      for (int n = 0; n < 30; n++) begin
         ra = ($urandom_range(0, 1) != 0) ? 20'($urandom_range(0, 63))
                                          : 20'hFFFF0 + 20'($urandom_range(0, 15));
         run_cmd(2'($urandom_range(0, 3)), ra, 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0), {$urandom, $urandom});
      end
      host_auto = 1'b0;

      // Write stall, then reset mid-burst.
      rdata_ready = 1'b0; wdata_valid = 1'b0;
      wr_cnt = 0; wr_viol = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 20'h00300; cmd_len = 4'd3; cmd_force = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      wdata_valid = 1'b1; wdata = 64'h0123_4567_89AB_CDEF; wtag = 8'h01;
      repeat (2) @(negedge clk);
      wdata_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("stall_wr_cnt", 72'(wr_cnt), 72'(2));
      check("stall_count", 72'(count), 72'(2));
      check("stall_no_wr", 72'(wr_viol), 72'(0));
      check("stall_state", 72'(dbg_state), 72'(3));
      reset = 1'b1;
      @(negedge clk);
      check("midrst_strobes", {m_astb, m_rd, m_wr, m_atomic, m_wforce, wdata_ready}, 72'(0));
      check("midrst_state", 72'(dbg_state), 72'(0));
      check("midrst_count", 72'(count), 72'(0));
      reset = 1'b0;
      @(negedge clk);
      check("midrst_ready", 72'(cmd_ready), 72'(1));

      // Reset with a read word in flight: that word must never appear.
      rdata_ready = 1'b1;
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 20'h00400; cmd_len = 4'd7; cmd_force = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      t = 0;
      while (!m_rd && t < 20) begin @(negedge clk); t++; end
      check("inflight_rd_seen", 72'(m_rd), 72'(1));
      reset = 1'b1;
      @(negedge clk);
      check("inflight_dropped", 72'(rdata_valid), 72'(0));
      check("inflight_state", 72'(dbg_state), 72'(0));
      reset = 1'b0;
      rdata_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("inflight_quiet", {rdata_valid, m_rd, done}, 72'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
